// File: rtl/gpsreceiver2_pkg.sv
// gpsreceiver2 sampler shared types: FSM state encoding, default widths,
// and sample-code field positions used by the packer and the top level.
package gpsreceiver2_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int WRAP_W_DEF = 16;

   localparam int CODE_W   = 2;
   localparam int SIGN_POS = 1;
   localparam int MAG_POS  = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   function automatic logic [CODE_W-1:0] mk_code(input logic s,
                                                 input logic m);
      logic [CODE_W-1:0] c;
      c           = '0;
      c[SIGN_POS] = s;
      c[MAG_POS]  = m;
      return c;
   endfunction

endpackage

// File: rtl/gpsreceiver2_packer.sv
// Packs four 2-bit sample codes into one byte, first sample in the LSBs.
// Ports: sys_clk/sys_rst, clr (drop partial byte), en + code (one sample),
// byte_valid/pk_byte (combinational, asserted with the 4th sample).
module gpsreceiver2_packer
   import gpsreceiver2_pkg::*;
(
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              clr,
   input  logic              en,
   input  logic [CODE_W-1:0] code,
   output logic              byte_valid,
   output logic [7:0]        pk_byte
);

   logic [1:0] phase;
   logic [5:0] sr;

   // Right-shifting keeps the oldest sample at the bottom, so the
   // completed byte is just the newest code on top of the history.
   assign byte_valid = en && !clr && (phase == 2'd3);
   assign pk_byte    = {code, sr};

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         phase <= 2'd0;
         sr    <= 6'd0;
      end else if (clr) begin
         phase <= 2'd0;
      end else if (en) begin
         phase <= phase + 2'd1;
         sr    <= {code, sr[5:2]};
      end
   end

endmodule

// File: rtl/gpsreceiver2_sampler.sv
// GPS front-end sampler: packs sign/magnitude samples into bytes and writes
// them to the sample buffer port (rxb0_*), single-shot or ring, with an
// optional PPS-aligned start. Ports: sys_clk/sys_rst, fe_* sample input,
// pps/start/stop/cont/trig_pps/len control, busy/done/irq/wr_ptr/wraps status.
module gpsreceiver2_sampler
   import gpsreceiver2_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int WRAP_W = WRAP_W_DEF
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              fe_sign,
   input  logic              fe_mag,
   input  logic              fe_valid,
   input  logic              pps,
   input  logic              start,
   input  logic              stop,
   input  logic              cont,
   input  logic              trig_pps,
   input  logic [ADDR_W-1:0] len,
   output logic              busy,
   output logic              done,
   output logic              irq,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [WRAP_W-1:0] wraps,
   output logic [7:0]        rxb0_dat,
   output logic [ADDR_W-1:0] rxb0_adr,
   output logic              rxb0_we
);

   state_t state, state_nx;

   logic              pps_d;
   logic              pps_rise;
   logic              cont_q;
   logic [ADDR_W-1:0] len_q;
   logic              accept;
   logic              capt;
   logic              pk_en;
   logic              pk_clr;
   logic              byte_valid;
   logic [7:0]        pk_byte;
   logic              last;

   assign pps_rise = pps && !pps_d;
   assign capt     = (state == ST_CAPTURE);
   // stop has priority, so a simultaneous start is dropped
   assign accept   = (state == ST_IDLE) && start && !stop;
   // a 4th sample arriving with stop is part of the discarded byte
   assign pk_en    = capt && fe_valid && !stop;
   assign pk_clr   = !capt || stop;
   assign last     = !cont_q && (wr_ptr == len_q);
   assign busy     = (state != ST_IDLE);

   gpsreceiver2_packer u_packer (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .clr        (pk_clr),
      .en         (pk_en),
      .code       (mk_code(fe_sign, fe_mag)),
      .byte_valid (byte_valid),
      .pk_byte    (pk_byte)
   );

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: begin
            if (accept)
               state_nx = trig_pps ? ST_ARMED : ST_CAPTURE;
         end
         ST_ARMED: begin
            if (stop)          state_nx = ST_IDLE;
            else if (pps_rise) state_nx = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (stop)                    state_nx = ST_IDLE;
            else if (byte_valid && last) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         pps_d    <= 1'b0;
         cont_q   <= 1'b0;
         len_q    <= '0;
         done     <= 1'b0;
         irq      <= 1'b0;
         wr_ptr   <= '0;
         wraps    <= '0;
         rxb0_dat <= 8'd0;
         rxb0_adr <= '0;
         rxb0_we  <= 1'b0;
      end else begin
         pps_d   <= pps;
         rxb0_we <= 1'b0;
         irq     <= 1'b0;
         if (accept) begin
            cont_q <= cont;
            len_q  <= len;
            done   <= 1'b0;
            wr_ptr <= '0;
            wraps  <= '0;
         end
         if (byte_valid) begin
            rxb0_we  <= 1'b1;
            rxb0_dat <= pk_byte;
            rxb0_adr <= wr_ptr;
            wr_ptr   <= wr_ptr + 1'b1;
            // status lands in the same cycle as the final write strobe
            if (last) begin
               done <= 1'b1;
               irq  <= 1'b1;
            end
            if (cont_q && (&wr_ptr) && !(&wraps))
               wraps <= wraps + 1'b1;
         end
      end
   end

endmodule
